// File: rtl/avg_pkg.sv
// Shared types and default sizing for the sequenced averaging engine.
package avg_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int DEF_DATAWIDTH    = 16;
  localparam int DEF_ACCWIDTH     = 32;
  localparam int DEF_NUM_SAMPLES  = 8;
  localparam int DEF_SHIFT_STAGES = 3;

  // Width able to hold the count 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_SAMPLE_CNT_W = cnt_w(DEF_NUM_SAMPLES);
  localparam int DEF_SHIFT_CNT_W  = cnt_w(DEF_SHIFT_STAGES);

endpackage

// File: rtl/avg_seq_ctrl_if.sv
// Sample-in / average-out handshake bundle; slave is the engine, master the environment.
interface avg_seq_ctrl_if
  import avg_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] in_data;
  logic [7:0]           sa;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] avg;

  modport slave (
    input  in_valid, in_data, sa, out_ready,
    output in_ready, out_valid, avg
  );

  modport master (
    output in_valid, in_data, sa, out_ready,
    input  in_ready, out_valid, avg
  );
endinterface

// File: rtl/avg_acc_dp.sv
// Accumulator with one shared adder and one shared shifter, plus output narrowing.
// Build option AVG_SATURATE_EN: clamp the result to all ones instead of truncating.
module avg_acc_dp
  import avg_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ACCWIDTH  = DEF_ACCWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic                 shift_i,
  input  logic                 out_en_i,
  input  logic [DATAWIDTH-1:0] data_i,
  input  logic [7:0]           sa_i,
  output logic [DATAWIDTH-1:0] avg_o
);

  logic [ACCWIDTH-1:0] acc_q, acc_d;

  // Shift amounts at or beyond the accumulator width flush it to zero.
  function automatic logic [ACCWIDTH-1:0] shr_flush(input logic [ACCWIDTH-1:0] v,
                                                    input logic [7:0]          amt);
    if (int'(amt) >= ACCWIDTH) return '0;
    return v >> amt;
  endfunction

  function automatic logic [DATAWIDTH-1:0] narrow(input logic [ACCWIDTH-1:0] v);
`ifdef AVG_SATURATE_EN
    if ((v >> DATAWIDTH) != '0) return '1;
    return DATAWIDTH'(v);
`else
    return DATAWIDTH'(v);
`endif
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (clear_i)      acc_d = '0;
    else if (add_i)   acc_d = acc_q + ACCWIDTH'(data_i);
    else if (shift_i) acc_d = shr_flush(acc_q, sa_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign avg_o = out_en_i ? narrow(acc_q) : '0;

endmodule

// File: rtl/avg_seq_ctrl.sv
// Sequencer for the resource-shared averaging engine: ACCUM -> SHIFT -> OUT.
// Optional build macro AVG_SATURATE_EN selects saturating output in avg_acc_dp.
module avg_seq_ctrl
  import avg_pkg::*;
#(
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int ACCWIDTH     = DEF_ACCWIDTH,
  parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int SHIFT_STAGES = DEF_SHIFT_STAGES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  avg_seq_ctrl_if.slave                  bus,
  output logic                           busy_o,
  output logic [cnt_w(NUM_SAMPLES)-1:0]  sample_cnt_o
);

  localparam int SCW = cnt_w(NUM_SAMPLES);
  localparam int HCW = cnt_w(SHIFT_STAGES);

  state_e         state_q, state_d;
  logic [SCW-1:0] sample_cnt_q, sample_cnt_d;
  logic [HCW-1:0] shift_cnt_q, shift_cnt_d;
  logic [7:0]     sa_q, sa_d;

  logic in_ready, out_valid, busy;
  logic accept, last_beat, shift_done, xfer;

  assign accept     = bus.in_valid && in_ready;
  assign last_beat  = accept && (sample_cnt_q == SCW'(NUM_SAMPLES - 1));
  assign shift_done = (state_q == SHIFT) && (shift_cnt_q == HCW'(SHIFT_STAGES - 1));
  assign xfer       = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last_beat)  state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = OUT;
      OUT:     if (xfer)       state_d = ACCUM;
      default:                 state_d = ACCUM;
    endcase
  end

  // Handshake outputs depend on state only, never on the inputs.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ACCUM:   in_ready = 1'b1;
      SHIFT:   busy     = 1'b1;
      OUT:   begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    shift_cnt_d  = shift_cnt_q;
    sa_d         = sa_q;
    if (accept) sample_cnt_d = sample_cnt_q + SCW'(1);
    if (last_beat) begin
      sa_d        = bus.sa;
      shift_cnt_d = '0;
    end
    if (state_q == SHIFT) shift_cnt_d = shift_cnt_q + HCW'(1);
    if (xfer)             sample_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      shift_cnt_q  <= '0;
      sa_q         <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      shift_cnt_q  <= shift_cnt_d;
      sa_q         <= sa_d;
    end
  end

  avg_acc_dp #(
    .DATAWIDTH (DATAWIDTH),
    .ACCWIDTH  (ACCWIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (xfer),
    .add_i    (accept),
    .shift_i  (state_q == SHIFT),
    .out_en_i (out_valid),
    .data_i   (bus.in_data),
    .sa_i     (sa_q),
    .avg_o    (bus.avg)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign busy_o        = busy;
  assign sample_cnt_o  = sample_cnt_q;

endmodule
